// File: rtl/ndn_pkg.sv
// Shared definitions for the NDN Data ingress parser and the FIB data path.
//   - FSM state encoding of the ingress parser
//   - prefix / prefix-length widths
//   - Data packet type byte, default payload size and accept timeout
package ndn_pkg;

  localparam int unsigned NDN_PREFIX_W       = 64;
  localparam int unsigned NDN_LEN_W          = 6;
  localparam logic [7:0]  NDN_DATA_TYPE      = 8'h06;
  // Shared with the FIB: payload bytes moved per packet.
  localparam int unsigned NDN_PAYLOAD_BYTES  = 1024;
  localparam int unsigned NDN_ACCEPT_TIMEOUT = 256;

  typedef enum logic [2:0] {
    StIdle,
    StHdrLen,
    StHdrPfx,
    StAnnounce,
    StWaitAcc,
    StPayload,
    StDrop
  } ndn_state_e;

endpackage

// File: rtl/ndn_data_ingress_parser_if.sv
// Link + FIB handshake bundle of the NDN Data ingress parser.
//   Link side : in_byte, in_valid -> parser; in_ready <- parser
//   FIB side  : ready_for_data -> parser; data_prefix, data_len, data_ready,
//               data_out, data_out_valid <- parser
//   Status    : drop_pulse, underrun (+ pkt_count, drop_count when
//               NDN_INGRESS_STATS_EN is defined) <- parser
// Modports: master = link/FIB environment, slave = the parser.
interface ndn_data_ingress_parser_if;
  import ndn_pkg::*;

  logic [7:0]              in_byte;
  logic                    in_valid;
  logic                    in_ready;
  logic                    ready_for_data;
  logic [NDN_PREFIX_W-1:0] data_prefix;
  logic [NDN_LEN_W-1:0]    data_len;
  logic                    data_ready;
  logic [7:0]              data_out;
  logic                    data_out_valid;
  logic                    drop_pulse;
  logic                    underrun;
`ifdef NDN_INGRESS_STATS_EN
  logic [15:0]             pkt_count;
  logic [15:0]             drop_count;

  modport master (
    output in_byte, in_valid, ready_for_data,
    input  in_ready, data_prefix, data_len, data_ready, data_out, data_out_valid,
           drop_pulse, underrun, pkt_count, drop_count
  );
  modport slave (
    input  in_byte, in_valid, ready_for_data,
    output in_ready, data_prefix, data_len, data_ready, data_out, data_out_valid,
           drop_pulse, underrun, pkt_count, drop_count
  );
`else
  modport master (
    output in_byte, in_valid, ready_for_data,
    input  in_ready, data_prefix, data_len, data_ready, data_out, data_out_valid,
           drop_pulse, underrun
  );
  modport slave (
    input  in_byte, in_valid, ready_for_data,
    output in_ready, data_prefix, data_len, data_ready, data_out, data_out_valid,
           drop_pulse, underrun
  );
`endif

endinterface

// File: rtl/ndn_byte_counter.sv
// Loadable up/down counter with a terminal-count flag.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (has priority over en_i)
//   en_i       : step by one in the CountUp direction
//   tc_o       : count currently equals TcVal
module ndn_byte_counter #(
  parameter int unsigned      Width   = 8,
  parameter bit               CountUp = 1'b1,
  parameter logic [Width-1:0] TcVal   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = CountUp ? count_q + Width'(1) : count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TcVal);

endmodule

// File: rtl/ndn_data_ingress_parser.sv
// NDN Data ingress parser: byte-serial link -> FIB data path.
// Parses type, prefix length and 64-bit prefix, announces the header with a
// one-cycle data_ready, waits for ready_for_data and then passes the payload
// straight through (zero latency). Malformed or unaccepted packets are drained.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ndn_data_ingress_parser_if.slave (link, FIB and status signals)
// Optional: define NDN_INGRESS_STATS_EN to add saturating pkt_count/drop_count.
module ndn_data_ingress_parser
  import ndn_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = NDN_PAYLOAD_BYTES,
  parameter int unsigned ACCEPT_TIMEOUT = NDN_ACCEPT_TIMEOUT,
  parameter logic [7:0]  DATA_TYPE      = NDN_DATA_TYPE
) (
  input logic                      clk,
  input logic                      rst,
  ndn_data_ingress_parser_if.slave bus
);

  localparam int unsigned CntW = $clog2(PAYLOAD_BYTES + 10);
  localparam int unsigned TmoW = $clog2(ACCEPT_TIMEOUT);
  localparam int unsigned PfxBytes = NDN_PREFIX_W / 8;

  // Drain loads equal the bytes still owed by the link, so the byte that
  // takes the counter to zero is the last byte of the packet.
  localparam logic [CntW-1:0] TypeDrain = CntW'(PfxBytes + 1 + PAYLOAD_BYTES);
  localparam logic [CntW-1:0] LenDrain  = CntW'(PfxBytes + PAYLOAD_BYTES);
  localparam logic [CntW-1:0] PldCount  = CntW'(PAYLOAD_BYTES);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(ACCEPT_TIMEOUT - 1);

  ndn_state_e state_d, state_q;

  logic [NDN_PREFIX_W-1:0] data_prefix_d, data_prefix_q;
  logic [NDN_LEN_W-1:0]    data_len_d, data_len_q;
  logic                    underrun_d, underrun_q;

  logic            pfx_load, pfx_inc, pfx_last;
  logic            cnt_load, cnt_dec, cnt_last;
  logic [CntW-1:0] cnt_val;
  logic            tmo_load, tmo_inc, tmo_last;
  logic            len_we, pfx_shift, underrun_set;
  logic            data_ready, drop_pulse;

  ndn_byte_counter #(
    .Width   (3),
    .CountUp (1'b1),
    .TcVal   (3'd7)
  ) u_pfx_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pfx_load),
    .load_val_i (3'd0),
    .en_i       (pfx_inc),
    .tc_o       (pfx_last)
  );

  // Shared payload / drop down-counter; flags the final byte at count 1.
  ndn_byte_counter #(
    .Width   (CntW),
    .CountUp (1'b0),
    .TcVal   (CntW'(1))
  ) u_byte_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_dec),
    .tc_o       (cnt_last)
  );

  ndn_byte_counter #(
    .Width   (TmoW),
    .CountUp (1'b1),
    .TcVal   (TmoLast)
  ) u_tmo_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmo_load),
    .load_val_i (TmoW'(0)),
    .en_i       (tmo_inc),
    .tc_o       (tmo_last)
  );

  // in_ready is 1 in every state that consumes link bytes, so in_valid alone
  // marks a transfer inside those states.
  always_comb begin
    state_d      = state_q;
    data_ready   = 1'b0;
    drop_pulse   = 1'b0;
    underrun_set = 1'b0;
    pfx_load     = 1'b0;
    pfx_inc      = 1'b0;
    cnt_load     = 1'b0;
    cnt_val      = '0;
    cnt_dec      = 1'b0;
    tmo_load     = 1'b0;
    tmo_inc      = 1'b0;
    len_we       = 1'b0;
    pfx_shift    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.in_byte == DATA_TYPE) begin
            state_d = StHdrLen;
          end else begin
            state_d  = StDrop;
            cnt_load = 1'b1;
            cnt_val  = TypeDrain;
          end
        end
      end
      StHdrLen: begin
        if (bus.in_valid) begin
          len_we = 1'b1;
          if (bus.in_byte[7:NDN_LEN_W] != '0) begin
            state_d  = StDrop;
            cnt_load = 1'b1;
            cnt_val  = LenDrain;
          end else begin
            state_d  = StHdrPfx;
            pfx_load = 1'b1;
          end
        end
      end
      StHdrPfx: begin
        if (bus.in_valid) begin
          pfx_shift = 1'b1;
          pfx_inc   = 1'b1;
          if (pfx_last) begin
            state_d = StAnnounce;
          end
        end
      end
      StAnnounce: begin
        data_ready = 1'b1;
        tmo_load   = 1'b1;
        state_d    = StWaitAcc;
      end
      StWaitAcc: begin
        tmo_inc = 1'b1;
        // Acceptance wins over a simultaneous timeout.
        if (bus.ready_for_data) begin
          state_d  = StPayload;
          cnt_load = 1'b1;
          cnt_val  = PldCount;
        end else if (tmo_last) begin
          state_d  = StDrop;
          cnt_load = 1'b1;
          cnt_val  = PldCount;
        end
      end
      StPayload: begin
        if (!bus.in_valid) begin
          underrun_set = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        if (bus.in_valid) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            drop_pulse = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_prefix_d = data_prefix_q;
    if (pfx_shift) begin
      data_prefix_d = {data_prefix_q[NDN_PREFIX_W-9:0], bus.in_byte};
    end
    data_len_d = len_we ? bus.in_byte[NDN_LEN_W-1:0] : data_len_q;
    underrun_d = underrun_q | underrun_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      data_prefix_q <= '0;
      data_len_q    <= '0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_prefix_q <= data_prefix_d;
      data_len_q    <= data_len_d;
      underrun_q    <= underrun_d;
    end
  end

  logic in_ready_st;
  assign in_ready_st = state_q inside {StIdle, StHdrLen, StHdrPfx, StPayload, StDrop};

  // Held low during reset so no byte looks accepted while the FSM is cleared.
  assign bus.in_ready       = in_ready_st & ~rst;
  assign bus.data_prefix    = data_prefix_q;
  assign bus.data_len       = data_len_q;
  assign bus.data_ready     = data_ready;
  assign bus.data_out_valid = (state_q == StPayload) & bus.in_valid;
  assign bus.data_out       = bus.data_out_valid ? bus.in_byte : 8'h00;
  assign bus.drop_pulse     = drop_pulse;
  assign bus.underrun       = underrun_q;

`ifdef NDN_INGRESS_STATS_EN
  logic        pkt_done;
  logic [15:0] pkt_count_d, pkt_count_q;
  logic [15:0] drop_count_d, drop_count_q;

  assign pkt_done = (state_q == StPayload) & bus.in_valid & cnt_last;

  always_comb begin
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if (pkt_done && (pkt_count_q != 16'hFFFF)) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
    if (drop_pulse && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.pkt_count  = pkt_count_q;
  assign bus.drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_ndn_data_ingress_parser.sv
// Self-checking bench for ndn_data_ingress_parser: a table of whole-packet
// vectors plus hand-written back-to-back, underrun and mid-packet reset cases.
module tb_ndn_data_ingress_parser;
  import ndn_pkg::*;

  localparam int PB = NDN_PAYLOAD_BYTES;

  logic clk = 1'b0;
  logic rst;

  ndn_data_ingress_parser_if bus ();

  ndn_data_ingress_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  typ;
    logic [7:0]  len;
    logic [63:0] pfx;
    int          rfd;     // cycles from data_ready to ready_for_data, 0 = never
    int          rdy;     // expected data_ready cycles
    logic [5:0]  elen;
    int          eout;    // expected data_out_valid cycles
    int          edrop;   // expected drop_pulse cycles
    int          estall;  // expected cycles with in_valid && !in_ready
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_ready, n_out, n_drop, n_stall, mon_bad;
  logic [63:0] cap_pfx;
  logic [5:0]  cap_len;
  int rfd_delay = 0;
  int rfd_cnt = 0;
  bit link_dead = 1'b0;
  int exp_pkt = 0;
  int exp_drop = 0;

  function automatic logic [7:0] pay_byte(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_ready = 0; n_out = 0; n_drop = 0; n_stall = 0; mon_bad = 0;
    cap_pfx = '0; cap_len = '0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte and return #1 after the edge that transfers it.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    if (link_dead) return;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready) begin
      waited++;
      if (waited > 1000) begin
        checks++;
        errors++;
        link_dead = 1'b1;
        $display("FAIL link_stall: in_ready low for %0d cycles, expected a transfer", waited);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Full packet: type, length, 8 prefix bytes MSB first, PB payload bytes.
  task automatic send_pkt(input logic [7:0] typ, input logic [7:0] len,
                          input logic [63:0] pfx, input int gap_at);
    send_byte(typ);
    send_byte(len);
    for (int j = 7; j >= 0; j--) send_byte(pfx[j*8 +: 8]);
    for (int i = 0; i < PB; i++) begin
      if (i == gap_at) begin
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      send_byte(pay_byte(i));
    end
  endtask

  // FIB model: pulse ready_for_data rfd_delay cycles after data_ready.
  initial begin
    bus.ready_for_data = 1'b0;
    forever begin
      @(negedge clk);
      bus.ready_for_data = 1'b0;
      if (rfd_cnt > 0) begin
        rfd_cnt--;
        if (rfd_cnt == 0) bus.ready_for_data = 1'b1;
      end
      if (bus.data_ready && rfd_delay > 0) rfd_cnt = rfd_delay;
    end
  end

  // Output monitor, sampled mid-cycle.
  initial begin
    clr_mon();
    forever begin
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) n_stall++;
      if (bus.data_ready) begin
        n_ready++;
        cap_pfx = bus.data_prefix;
        cap_len = bus.data_len;
      end
      if (bus.drop_pulse) begin
        n_drop++;
        if (!(bus.in_valid && bus.in_ready)) mon_bad++;
      end
      if (bus.data_out_valid) begin
        if (bus.data_out !== pay_byte(n_out)) mon_bad++;
        if (bus.data_prefix !== cap_pfx) mon_bad++;
        n_out++;
      end else if (bus.data_out !== 8'h00) begin
        mon_bad++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded its time limit, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v [7];
    logic [63:0] p2;
    logic [63:0] exp_part;

    v[0] = '{typ: 8'h06, len: 8'h05, pfx: 64'h0102030405060708, rfd: 3,
             rdy: 1, elen: 6'd5, eout: PB, edrop: 0, estall: 4};
    v[1] = '{typ: 8'h05, len: 8'h05, pfx: 64'h1111111111111111, rfd: 3,
             rdy: 0, elen: 6'd0, eout: 0, edrop: 1, estall: 0};
    v[2] = '{typ: 8'h06, len: 8'h45, pfx: 64'h2222222222222222, rfd: 3,
             rdy: 0, elen: 6'd0, eout: 0, edrop: 1, estall: 0};
    v[3] = '{typ: 8'h06, len: 8'h3F, pfx: 64'hFEDCBA9876543210, rfd: 0,
             rdy: 1, elen: 6'h3F, eout: 0, edrop: 1, estall: 257};
    v[4] = '{typ: 8'h06, len: 8'h00, pfx: 64'h8000000000000001, rfd: 256,
             rdy: 1, elen: 6'd0, eout: PB, edrop: 0, estall: 257};
    v[5] = '{typ: 8'h06, len: 8'h21, pfx: 64'h0011223344556677, rfd: 257,
             rdy: 1, elen: 6'h21, eout: 0, edrop: 1, estall: 257};
    v[6] = '{typ: 8'h06, len: 8'h01, pfx: 64'hA5A5A5A55A5A5A5A, rfd: 1,
             rdy: 1, elen: 6'd1, eout: PB, edrop: 0, estall: 2};

    // Reset state.
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_data_prefix", bus.data_prefix, 0);
    chk("rst_data_len", bus.data_len, 0);
    chk("rst_data_ready", bus.data_ready, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_data_out_valid", bus.data_out_valid, 0);
    chk("rst_drop_pulse", bus.drop_pulse, 0);
    chk("rst_underrun", bus.underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 1);

    // Table-driven whole packets.
    for (int i = 0; i < 7; i++) begin
      clr_mon();
      rfd_delay = v[i].rfd;
      send_pkt(v[i].typ, v[i].len, v[i].pfx, -1);
      idle(3);
      chk($sformatf("v%0d_data_ready", i), n_ready, v[i].rdy);
      if (v[i].rdy != 0) begin
        chk($sformatf("v%0d_data_prefix", i), cap_pfx, v[i].pfx);
        chk($sformatf("v%0d_data_len", i), cap_len, v[i].elen);
      end
      chk($sformatf("v%0d_out_bytes", i), n_out, v[i].eout);
      chk($sformatf("v%0d_drop_pulse", i), n_drop, v[i].edrop);
      chk($sformatf("v%0d_stall_cycles", i), n_stall, v[i].estall);
      chk($sformatf("v%0d_monitor", i), mon_bad, 0);
      if (v[i].eout != 0) exp_pkt++;
      exp_drop += v[i].edrop;
    end
    chk("table_underrun", bus.underrun, 0);

    // Back-to-back: bad type drained, then a good packet with no idle gap.
    clr_mon();
    rfd_delay = 3;
    send_pkt(8'h05, 8'h05, 64'h3333333333333333, -1);
    send_pkt(8'h06, 8'h12, 64'h0F0E0D0C0B0A0908, -1);
    idle(3);
    chk("b2b_drop_pulse", n_drop, 1);
    chk("b2b_data_ready", n_ready, 1);
    chk("b2b_data_prefix", cap_pfx, 64'h0F0E0D0C0B0A0908);
    chk("b2b_data_len", cap_len, 6'h12);
    chk("b2b_out_bytes", n_out, PB);
    chk("b2b_stall_cycles", n_stall, 4);
    chk("b2b_monitor", mon_bad, 0);
    exp_pkt++;
    exp_drop++;

    // Link starves for 2 cycles before payload byte 500.
    clr_mon();
    rfd_delay = 3;
    send_pkt(8'h06, 8'h05, 64'h0102030405060708, 500);
    idle(3);
    chk("urun_underrun", bus.underrun, 1);
    chk("urun_out_bytes", n_out, PB);
    chk("urun_data_ready", n_ready, 1);
    chk("urun_drop_pulse", n_drop, 0);
    chk("urun_monitor", mon_bad, 0);
    exp_pkt++;
    p2 = 64'hCAFEBABE00000001;
    clr_mon();
    send_pkt(8'h06, 8'h10, p2, -1);
    idle(3);
    chk("urun_sticky", bus.underrun, 1);
    chk("urun2_out_bytes", n_out, PB);
    exp_pkt++;
`ifdef NDN_INGRESS_STATS_EN
    chk("stats_pkt_count", bus.pkt_count, exp_pkt);
    chk("stats_drop_count", bus.drop_count, exp_drop);
`endif

    // Reset while the 4th prefix byte is on the link.
    send_byte(8'h06);
    send_byte(8'h07);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    exp_part = {p2[39:0], 24'h010203};
    chk("pre_rst_prefix", bus.data_prefix, exp_part);
    chk("pre_rst_len", bus.data_len, 7);
    bus.in_byte  = 8'h04;
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_prefix", bus.data_prefix, 0);
    chk("mid_rst_len", bus.data_len, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_underrun", bus.underrun, 0);
    chk("mid_rst_data_out_valid", bus.data_out_valid, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clr_mon();
    rfd_delay = 2;
    send_pkt(8'h06, 8'h2A, 64'h1122334455667788, -1);
    idle(3);
    chk("post_rst_data_ready", n_ready, 1);
    chk("post_rst_data_prefix", cap_pfx, 64'h1122334455667788);
    chk("post_rst_data_len", cap_len, 6'h2A);
    chk("post_rst_out_bytes", n_out, PB);
    chk("post_rst_stall_cycles", n_stall, 3);
    chk("post_rst_monitor", mon_bad, 0);
`ifdef NDN_INGRESS_STATS_EN
    chk("post_rst_pkt_count", bus.pkt_count, 1);
    chk("post_rst_drop_count", bus.drop_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
